// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request/response handshake.
// Adds a fixed number of wait states, merges sub-word stores and extends sub-word loads.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_store,
    input  logic [2:0]  req_load,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              off_q, off_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [1:0]              store_q, store_d;
    logic [2:0]              load_q, load_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic        commit;
    logic        acc_err;
    logic [31:0] word_rd;
    logic [7:0]  byte_rd;
    logic [15:0] half_rd;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wword;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    // Misalignment and illegal encodings for the latched access.
    always_comb begin
        acc_err = 1'b0;
        if (we_q) begin
            case (store_q)
                2'b00:   acc_err = 1'b0;
                2'b01:   acc_err = off_q[0];
                2'b10:   acc_err = (off_q != 2'b00);
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (load_q)
                3'b000, 3'b100: acc_err = 1'b0;
                3'b001, 3'b101: acc_err = off_q[0];
                3'b010:         acc_err = (off_q != 2'b00);
                default:        acc_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        word_rd   = mem[idx_q];
        byte_rd   = word_rd[{off_q, 3'b000} +: 8];
        half_rd   = off_q[1] ? word_rd[31:16] : word_rd[15:0];
        load_data = word_rd;
        case (load_q[1:0])
            2'b00:   load_data = load_q[2] ? {24'd0, byte_rd} : {{24{byte_rd[7]}}, byte_rd};
            2'b01:   load_data = load_q[2] ? {16'd0, half_rd} : {{16{half_rd[15]}}, half_rd};
            default: load_data = word_rd;
        endcase
    end

    // Store data is replicated across lanes so the byte enables pick the right copy.
    always_comb begin
        be    = 4'b1111;
        wword = wdata_q;
        case (store_q)
            2'b00: begin
                be    = 4'b0001 << off_q;
                wword = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = off_q[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        store_d   = store_q;
        load_d    = load_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        commit    = 1'b0;
        req_ready = (state_q == S_IDLE) && !reset;
        rsp_valid = (state_q == S_RESP);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_addr[ADDR_WIDTH+1:2];
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    store_d = req_store;
                    load_d  = req_load;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    err_d   = acc_err;
                    rdata_d = (we_q || acc_err) ? 32'd0 : load_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            wdata_q <= 32'd0;
            store_q <= 2'b00;
            load_q  <= 3'b000;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            load_q  <= load_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is never cleared by reset; only the addressed lanes of a legal store change.
    always_ff @(posedge clk) begin
        if (commit && we_q && !acc_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx_q][i*8 +: 8] <= wword[i*8 +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a byte-level memory model scores every response cycle,
// while each directed access also carries a hand-computed expected result.
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_store;
    logic [2:0]  req_load;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  st;
        logic [2:0]  ld;
    } req_t;

    req_t        pend_q[$];
    logic [31:0] mm[int];

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_store (req_store),
        .req_load  (req_load),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes, or 0 for an illegal encoding.
    function automatic int acc_size(input req_t r);
        if (r.we) return (r.st == 2'b11) ? 0 : (1 << r.st);
        if (r.ld inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) return 1 << r.ld[1:0];
        return 0;
    endfunction

    function automatic bit model_err(input req_t r);
        int sz = acc_size(r);
        if (sz == 0) return 1'b1;
        return (int'(r.addr[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_rdata(input req_t r);
        int     idx = int'(r.addr[AW+1:2]);
        int     sz  = acc_size(r);
        longint w, mask, v;
        if (r.we || model_err(r)) return 32'd0;
        w    = mm.exists(idx) ? longint'(mm[idx]) : 64'd0;
        mask = (64'd1 << (8 * sz)) - 1;
        v    = (w >> (8 * int'(r.addr[1:0]))) & mask;
        if (!r.ld[2] && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | (~mask & 64'hFFFF_FFFF);
        return v[31:0];
    endfunction

    function automatic void model_apply(input req_t r);
        int     idx = int'(r.addr[AW+1:2]);
        int     sh  = 8 * int'(r.addr[1:0]);
        int     sz  = acc_size(r);
        longint w, mask, nv;
        if (!r.we || model_err(r)) return;
        w    = mm.exists(idx) ? longint'(mm[idx]) : 64'd0;
        mask = (64'd1 << (8 * sz)) - 1;
        nv   = (w & ~(mask << sh)) | ((longint'(r.wdata) & mask) << sh);
        mm[idx] = nv[31:0];
    endfunction

    // Per-cycle scoreboard on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
            chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end else if (rsp_valid) begin
            if (pend_q.size() == 0) begin
                chk("rsp_without_request", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("model_rdata", rsp_rdata, model_rdata(pend_q[0]));
                chk("model_err", {31'd0, rsp_err}, {31'd0, model_err(pend_q[0])});
                chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
                if (rsp_ready) begin
                    model_apply(pend_q[0]);
                    void'(pend_q.pop_front());
                end
            end
        end
    end

    task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] st, input logic [2:0] ld);
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_store = st;
        req_load  = ld;
        req_valid = 1'b1;
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] st, input logic [2:0] ld,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        req_t        r;
        int          edges;
        logic [31:0] held;
        @(posedge clk);
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        drive_req(we, a, wd, st, ld);
        r.we = we; r.addr = a; r.wdata = wd; r.st = st; r.ld = ld;
        @(posedge clk);
        pend_q.push_back(r);
        #1;
        req_valid = 1'b0;
        edges = 0;
        while (!rsp_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency_edges", edges, WC + 1);
        if (!rsp_valid) return;
        chk("lit_rdata", rsp_rdata, exp_rd);
        chk("lit_err", {31'd0, rsp_err}, {31'd0, exp_err});
        held = rsp_rdata;
        // A stray request offered during backpressure must be ignored.
        if (hold > 0) drive_req(1'b1, 32'h10, 32'h5A5A_5A5A, 2'b10, 3'b010);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, held);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_store = 2'b00;
        req_load  = 3'b000;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;

        // Word store and load back.
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 3'b010, 32'h0, 1'b0, 0);
        access(1'b0, 32'h10, 32'h0,         2'b00, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);

        // Byte store with sign/zero extension.
        access(1'b1, 32'h10, 32'h0,  2'b10, 3'b010, 32'h0, 1'b0, 0);
        access(1'b1, 32'h13, 32'h80, 2'b00, 3'b010, 32'h0, 1'b0, 0);
        access(1'b0, 32'h13, 32'h0,  2'b00, 3'b000, 32'hFFFF_FF80, 1'b0, 0);
        access(1'b0, 32'h13, 32'h0,  2'b00, 3'b100, 32'h0000_0080, 1'b0, 0);
        access(1'b0, 32'h10, 32'h0,  2'b00, 3'b010, 32'h8000_0000, 1'b0, 0);

        // Halfword stores into both halves.
        access(1'b1, 32'h20, 32'h0,    2'b10, 3'b010, 32'h0, 1'b0, 0);
        access(1'b1, 32'h22, 32'h1234, 2'b01, 3'b010, 32'h0, 1'b0, 0);
        access(1'b0, 32'h22, 32'h0,    2'b00, 3'b101, 32'h0000_1234, 1'b0, 0);
        access(1'b0, 32'h20, 32'h0,    2'b00, 3'b010, 32'h1234_0000, 1'b0, 0);
        access(1'b1, 32'h20, 32'h8001, 2'b01, 3'b010, 32'h0, 1'b0, 0);
        access(1'b0, 32'h20, 32'h0,    2'b00, 3'b001, 32'hFFFF_8001, 1'b0, 0);
        access(1'b0, 32'h20, 32'h0,    2'b00, 3'b101, 32'h0000_8001, 1'b0, 0);
        access(1'b0, 32'h22, 32'h0,    2'b00, 3'b000, 32'h0000_0034, 1'b0, 0);

        // Misaligned and illegal encodings leave RAM untouched.
        access(1'b0, 32'h21, 32'h0,         2'b00, 3'b001, 32'h0, 1'b1, 0);
        access(1'b1, 32'h12, 32'h1234_5678, 2'b10, 3'b010, 32'h0, 1'b1, 0);
        access(1'b1, 32'h10, 32'hFFFF_FFFF, 2'b11, 3'b010, 32'h0, 1'b1, 0);
        access(1'b0, 32'h10, 32'h0,         2'b00, 3'b011, 32'h0, 1'b1, 0);
        access(1'b0, 32'h10, 32'h0,         2'b00, 3'b010, 32'h8000_0000, 1'b0, 0);
        access(1'b0, 32'h1010, 32'h0,       2'b00, 3'b010, 32'h8000_0000, 1'b0, 0);

        // Backpressure.
        access(1'b0, 32'h20, 32'h0, 2'b00, 3'b010, 32'h1234_8001, 1'b0, 4);
        access(1'b0, 32'h10, 32'h0, 2'b00, 3'b010, 32'h8000_0000, 1'b0, 0);

        // Reset in the middle of a store's wait states.
        access(1'b1, 32'h30, 32'h0, 2'b10, 3'b010, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        drive_req(1'b1, 32'h30, 32'hFFFF_FFFF, 2'b10, 3'b010);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        chk("abort_err", {31'd0, rsp_err}, 32'd0);
        pend_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        access(1'b0, 32'h30, 32'h0, 2'b00, 3'b010, 32'h0, 1'b0, 0);

        // Byte store ignores upper wdata bits.
        access(1'b1, 32'h31, 32'hFFFF_FF55, 2'b00, 3'b010, 32'h0, 1'b0, 0);
        access(1'b0, 32'h30, 32'h0, 2'b00, 3'b010, 32'h0000_5500, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
